jesd204b_dll_rx_lane: RTL
=========================

// Module: jesd204b_dll_rx_lane
// PURPOSE
//  Per-lane receive data link layer: CGS, ILAS check, frame/multiframe alignment, /F/ /A/ replacement undo.
//  Input is one 8b/10b-decoded octet per clk. Output is one F-octet frame word per frame, ready for the RX transport mapper.
//  One instance per lane. The lane's sync_n outputs are ANDed externally. Scrambling is not supported.
// PARAMETERS
//  OCTETS   2   F, octets per frame per lane (1..8)
//  FRAMES   32  K, frames per multiframe (1..32, with F*K >= 17)
//  ILAS_MF  4   ILAS length in multiframes (>= 1)
// PORTS
//  clk          in   1        single clock, octet rate
//  rst_n        in   1        asynchronous active-low reset
//  rx_octet     in   8        decoded octet
//  rx_charisk   in   1        1 = rx_octet is a control character
//  rx_disperr   in   1        8b/10b disparity / not-in-table error for this octet
//  sync_n       out  1        0 = request sync (CGS)
//  frame_data   out  8*F      octet 0 in [8F-1:8F-8], last octet in [7:0]
//  frame_valid  out  1        one-cycle strobe, frame_data is valid
//  mf_start     out  1        with frame_valid, frame is frame 0 of a multiframe
//  ilas_done    out  1        high while in DATA
//  lane_state   out  2        0 INIT, 1 CHECK, 2 ILAS, 3 DATA
//  align_err    out  1        one-cycle pulse on alignment/control error
// BEHAVIOUR
//  Reset (async assert, sync release): state INIT. All outputs 0, so sync_n=0. Counters and the last-octet register are 0.
//  /K/=K28.5 (charisk,0xBC); /R/=0x1C; /A/=0x7C; /F/=0xFC. A control char is valid only with charisk=1 and disperr=0.
//  INIT: sync_n=0. A valid /K/ -> CHECK, kcnt=1.
//  CHECK: sync_n=0.
//   - valid /K/: kcnt++. On the 4th consecutive /K/, go to CGS_DONE: sync_n=1 from the next cycle and stay in CHECK.
//   - any other octet before 4 /K/: -> INIT.
//   - after CGS_DONE, further /K/ are ignored.
//   - first non-/K/ octet after CGS_DONE must be a valid /R/ -> ILAS. This octet is octet 0, frame 0, multiframe 0.
//   - if it is not /R/: align_err pulse, -> INIT.
//  Alignment counters: octet cnt 0..F-1 and frame cnt 0..K-1 advance every cycle from /R/ onward.
//  ILAS: frames are not output (frame_valid=0).
//   - Last octet of each multiframe must be a valid /A/; otherwise align_err pulse, -> INIT.
//   - After the /A/ ending multiframe ILAS_MF-1, -> DATA next cycle. ilas_done=1.
//  DATA: octets are shifted into the frame word.
//   - Last octet of frame (not end of multiframe): a valid /F/ is replaced by the stored last octet of the previous frame.
//   - Last octet of multiframe: a valid /A/ is replaced the same way.
//   - /F/ or /A/ at any other position: passed through unchanged, align_err pulse, state unchanged.
//   - /K/ in DATA: align_err pulse, octet passed through.
//   - The last-octet register always holds the post-replacement last octet.
//  Output timing:
//   - frame_valid and frame_data register 1 cycle after the frame's last octet is sampled. Latency is 1 clk from the last octet.
//   - mf_start=1 when frame cnt was 0.
//   - Strobe period is exactly F clks.
//  Errors:
//   - rx_disperr on 4 consecutive octets in ILAS or DATA -> INIT, sync_n=0 next cycle, partial frame discarded.
//   - A single error octet is passed through and resets the error count only on a clean octet.
//  Reset mid-frame: everything clears immediately. No partial frame is emitted.
//  F=1: every octet is the last octet of its frame.
// TESTING
//  1. Reset, then 4 /K/ -> sync_n rises the cycle after the 4th /K/. Only 3 /K/ then 0x00 -> state INIT, sync_n stays 0.
//  2. CGS, then /R/ + 4 ILAS multiframes ending in /A/, then data 0x11,0x22,... (F=2)
//     -> ilas_done=1, first frame_data=16'h1122 one clk after 0x22, frame_valid every 2 clks.
//  3. DATA, frame n ends 0x5A, frame n+1 octet1=/F/ -> frame n+1 low byte=0x5A, no align_err.
//     /A/ at multiframe end behaves likewise.
//  4. ILAS multiframe 1 missing /A/ (data 0x00) -> align_err pulse, state INIT, sync_n=0.
//  5. /F/ at octet 0 in DATA -> 0xFC passed through, align_err 1 clk, alignment unchanged.
//  6. 4 consecutive rx_disperr in DATA -> INIT, sync_n=0. rst_n low mid-frame -> all outputs 0, no frame_valid.

Source files
------------

// File: rtl/jesd204b_dll_rx_lane.sv
// JESD204B receive data link layer for one lane: code group sync, ILAS check,
// frame/multiframe alignment and /F/ /A/ character replacement undo.
module jesd204b_dll_rx_lane #(
  parameter int unsigned OCTETS  = 2,
  parameter int unsigned FRAMES  = 32,
  parameter int unsigned ILAS_MF = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_octet,
  input  logic                  rx_charisk,
  input  logic                  rx_disperr,
  output logic                  sync_n,
  output logic [8*OCTETS-1:0]   frame_data,
  output logic                  frame_valid,
  output logic                  mf_start,
  output logic                  ilas_done,
  output logic [1:0]            lane_state,
  output logic                  align_err
);

  localparam int unsigned W  = 8 * OCTETS;
  localparam int unsigned OW = (OCTETS  > 1) ? $clog2(OCTETS)  : 1;
  localparam int unsigned FW = (FRAMES  > 1) ? $clog2(FRAMES)  : 1;
  localparam int unsigned MW = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
  localparam logic [OW-1:0] OCT_LAST = OW'(OCTETS - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(FRAMES - 1);
  localparam logic [MW-1:0] MF_LAST  = MW'(ILAS_MF - 1);
  localparam logic [7:0] K_CHAR = 8'hBC;
  localparam logic [7:0] R_CHAR = 8'h1C;
  localparam logic [7:0] A_CHAR = 8'h7C;
  localparam logic [7:0] F_CHAR = 8'hFC;

  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_CHECK = 2'd1, ST_ILAS = 2'd2, ST_DATA = 2'd3} state_t;

  state_t        state, state_nxt;
  logic [2:0]    kcnt, kcnt_nxt;
  logic          cgs_done, cgs_done_nxt;
  logic [OW-1:0] oct_cnt, oct_cnt_nxt, oct_adv;
  logic [FW-1:0] frm_cnt, frm_cnt_nxt, frm_adv;
  logic [MW-1:0] mf_cnt, mf_cnt_nxt, mf_adv;
  logic [1:0]    err_cnt, err_cnt_nxt;
  logic [W-1:0]  acc, acc_nxt, fd_nxt;
  logic [7:0]    last_oct, last_oct_nxt, oct_out;
  logic          sync_n_nxt, fv_nxt, mfs_nxt, ilas_nxt, aerr_nxt;
  logic          is_ctrl, is_k, is_r, is_a, is_f, oct_last, mf_last, go_init;

  assign lane_state = state;

  // Character decode and alignment position of the current octet
  always_comb begin
    is_ctrl  = rx_charisk && !rx_disperr;
    is_k     = is_ctrl && (rx_octet == K_CHAR);
    is_r     = is_ctrl && (rx_octet == R_CHAR);
    is_a     = is_ctrl && (rx_octet == A_CHAR);
    is_f     = is_ctrl && (rx_octet == F_CHAR);
    oct_last = (oct_cnt == OCT_LAST);
    mf_last  = oct_last && (frm_cnt == FRM_LAST);
    oct_adv  = oct_cnt;
    frm_adv  = frm_cnt;
    mf_adv   = mf_cnt;
    if (oct_last) begin
      oct_adv = '0;
      if (frm_cnt == FRM_LAST) begin
        frm_adv = '0;
        mf_adv  = mf_cnt + 1'b1;
      end else begin
        frm_adv = frm_cnt + 1'b1;
      end
    end else begin
      oct_adv = oct_cnt + 1'b1;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt    = state;
    kcnt_nxt     = kcnt;
    cgs_done_nxt = cgs_done;
    oct_cnt_nxt  = oct_cnt;
    frm_cnt_nxt  = frm_cnt;
    mf_cnt_nxt   = mf_cnt;
    err_cnt_nxt  = err_cnt;
    acc_nxt      = acc;
    last_oct_nxt = last_oct;
    fd_nxt       = frame_data;
    fv_nxt       = 1'b0;
    mfs_nxt      = 1'b0;
    aerr_nxt     = 1'b0;
    oct_out      = rx_octet;
    go_init      = 1'b0;

    unique case (state)
      ST_INIT: begin
        if (is_k) begin
          state_nxt = ST_CHECK;
          kcnt_nxt  = 3'd1;
        end
      end
      ST_CHECK: begin
        if (cgs_done) begin
          if (is_r) begin
            state_nxt   = ST_ILAS;
            oct_cnt_nxt = oct_adv;
            frm_cnt_nxt = frm_adv;
            mf_cnt_nxt  = mf_adv;
          end else if (!is_k) begin
            aerr_nxt = 1'b1;
            go_init  = 1'b1;
          end
        end else if (is_k) begin
          kcnt_nxt = kcnt + 3'd1;
          if (kcnt == 3'd3) cgs_done_nxt = 1'b1;
        end else begin
          go_init = 1'b1;
        end
      end
      ST_ILAS: begin
        oct_cnt_nxt = oct_adv;
        frm_cnt_nxt = frm_adv;
        mf_cnt_nxt  = mf_adv;
        if (oct_last) last_oct_nxt = rx_octet;
        if (mf_last) begin
          if (!is_a) begin
            aerr_nxt = 1'b1;
            go_init  = 1'b1;
          end else if (mf_cnt == MF_LAST) begin
            state_nxt = ST_DATA;
          end
        end
      end
      default: begin
        oct_cnt_nxt = oct_adv;
        frm_cnt_nxt = frm_adv;
        mf_cnt_nxt  = mf_adv;
        // Undo transmitter character replacement at frame/multiframe ends
        if ((is_f && oct_last && !mf_last) || (is_a && mf_last)) oct_out = last_oct;
        if ((is_f && !(oct_last && !mf_last)) || (is_a && !mf_last) || is_k) aerr_nxt = 1'b1;
        acc_nxt = W'({acc, oct_out});
        if (oct_last) begin
          fv_nxt       = 1'b1;
          fd_nxt       = acc_nxt;
          mfs_nxt      = (frm_cnt == '0);
          last_oct_nxt = oct_out;
        end
      end
    endcase

    // Four consecutive disparity errors drop the link
    if (state == ST_ILAS || state == ST_DATA) begin
      if (rx_disperr) begin
        err_cnt_nxt = err_cnt + 2'd1;
        if (err_cnt == 2'd3) go_init = 1'b1;
      end else begin
        err_cnt_nxt = '0;
      end
    end

    if (go_init) begin
      state_nxt    = ST_INIT;
      kcnt_nxt     = '0;
      cgs_done_nxt = 1'b0;
      oct_cnt_nxt  = '0;
      frm_cnt_nxt  = '0;
      mf_cnt_nxt   = '0;
      err_cnt_nxt  = '0;
      acc_nxt      = '0;
      last_oct_nxt = '0;
      fv_nxt       = 1'b0;
      mfs_nxt      = 1'b0;
    end

    sync_n_nxt = (state_nxt == ST_CHECK && cgs_done_nxt) ||
                 (state_nxt == ST_ILAS) || (state_nxt == ST_DATA);
    ilas_nxt   = (state_nxt == ST_DATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      kcnt        <= '0;
      cgs_done    <= 1'b0;
      oct_cnt     <= '0;
      frm_cnt     <= '0;
      mf_cnt      <= '0;
      err_cnt     <= '0;
      acc         <= '0;
      last_oct    <= '0;
      sync_n      <= 1'b0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      mf_start    <= 1'b0;
      ilas_done   <= 1'b0;
      align_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      kcnt        <= kcnt_nxt;
      cgs_done    <= cgs_done_nxt;
      oct_cnt     <= oct_cnt_nxt;
      frm_cnt     <= frm_cnt_nxt;
      mf_cnt      <= mf_cnt_nxt;
      err_cnt     <= err_cnt_nxt;
      acc         <= acc_nxt;
      last_oct    <= last_oct_nxt;
      sync_n      <= sync_n_nxt;
      frame_data  <= fd_nxt;
      frame_valid <= fv_nxt;
      mf_start    <= mfs_nxt;
      ilas_done   <= ilas_nxt;
      align_err   <= aerr_nxt;
    end
  end

endmodule
